// File: rtl/led_pattern_arbiter_pkg.sv
// Shared types and width helpers for the LED pattern arbiter.
// Holds the FSM state encoding and index-width calculations used by every file.
package led_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        PLAY = 1'b1
    } arb_state_e;

    localparam int N_REQ_DEF    = 4;
    localparam int PAT_W_DEF    = 32;
    localparam int TICK_DIV_DEF = 1048576;

    // Width of an index over n items, never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/led_pattern_arbiter_if.sv
// Requester-side bus of the LED arbiter: level requests and pattern slices in,
// LED drive and grant/status out.
interface led_pattern_arbiter_if #(
    parameter int N_REQ = led_arb_pkg::N_REQ_DEF,
    parameter int PAT_W = led_arb_pkg::PAT_W_DEF
);
    import led_arb_pkg::*;

    logic [N_REQ-1:0]       REQ;
    logic [N_REQ*PAT_W-1:0] PATTERN;
    logic                   LED;
    logic [N_REQ-1:0]       GNT;
    logic                   BUSY;
    logic                   DONE;

    modport master (output REQ, PATTERN, input LED, GNT, BUSY, DONE);
    modport slave  (input REQ, PATTERN, output LED, GNT, BUSY, DONE);

endinterface

// File: rtl/led_pattern_arbiter_tick_gen.sv
// Bit-period prescaler: counts 0..TICK_DIV-1 while enabled and flags the last
// and second-to-last cycle of each period.
module led_tick_gen
    import led_arb_pkg::*;
#(
    parameter int TICK_DIV = TICK_DIV_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic tick_o,
    output logic pre_tick_o
);
    localparam int              TW       = idx_w(TICK_DIV);
    localparam logic [TW-1:0]   CNT_LAST = TW'(TICK_DIV - 1);
    localparam logic [TW-1:0]   CNT_PRE  = TW'(TICK_DIV - 2);

    logic [TW-1:0] cnt_q, cnt_d;

    // pre_tick lets the owner register a pulse that lands on the final cycle.
    assign tick_o     = en_i && (cnt_q == CNT_LAST);
    assign pre_tick_o = en_i && (cnt_q == CNT_PRE);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = tick_o ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/led_pattern_arbiter.sv
// Round-robin owner of the user LED: latches the winner's pattern and plays it
// LSB-first, one bit per prescaler period, without preemption.
module led_pattern_arbiter
    import led_arb_pkg::*;
#(
    parameter int N_REQ    = N_REQ_DEF,
    parameter int PAT_W    = PAT_W_DEF,
    parameter int TICK_DIV = TICK_DIV_DEF
) (
    input  logic                 CLK,
    input  logic                 RST,
    led_pattern_arbiter_if.slave bus
);
    localparam int                 PTR_W    = idx_w(N_REQ);
    localparam int                 BW       = idx_w(PAT_W);
    localparam logic [BW-1:0]      BIT_LAST = BW'(PAT_W - 1);
    localparam logic [PTR_W-1:0]   PTR_LAST = PTR_W'(N_REQ - 1);

    arb_state_e        state_q, state_d;
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic [PTR_W-1:0]  idx_q, idx_d;
    logic [BW-1:0]     bit_q, bit_d;
    logic [PAT_W-1:0]  shadow_q, shadow_d;
    logic [N_REQ-1:0]  gnt_q, gnt_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [PTR_W-1:0]  win;
    logic              load;
    logic              tick, pre_tick, tick_clr;

    // First requesting index at or above ptr, wrapping; callers gate on |req.
    function automatic logic [PTR_W-1:0] rr_pick(input logic [N_REQ-1:0] req,
                                                 input logic [PTR_W-1:0] ptr);
        logic [PTR_W-1:0] pick;
        logic             found;
        pick  = '0;
        found = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            int j;
            j = (int'(ptr) + i) % N_REQ;
            if (!found && req[j]) begin
                found = 1'b1;
                pick  = PTR_W'(j);
            end
        end
        return pick;
    endfunction

    led_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk       (CLK),
        .rst       (RST),
        .clr_i     (tick_clr),
        .en_i      (state_q == PLAY),
        .tick_o    (tick),
        .pre_tick_o(pre_tick)
    );

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        idx_d    = idx_q;
        bit_d    = bit_q;
        shadow_d = shadow_q;
        gnt_d    = gnt_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        load     = 1'b0;
        tick_clr = 1'b0;
        case (state_q)
            IDLE: load = |bus.REQ;
            PLAY: begin
                if (pre_tick && bit_q == BIT_LAST) begin
                    done_d = 1'b1;
                end
                if (tick) begin
                    if (bit_q == BIT_LAST) begin
                        ptr_d = (idx_q == PTR_LAST) ? '0 : idx_q + 1'b1;
                        load  = |bus.REQ;
                        if (!load) begin
                            state_d = IDLE;
                            gnt_d   = '0;
                            busy_d  = 1'b0;
                            bit_d   = '0;
                        end
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        // Arbitrate against the already-advanced pointer so back-to-back
        // grants rotate away from the requester just served.
        win = rr_pick(bus.REQ, ptr_d);
        if (load) begin
            state_d      = PLAY;
            idx_d        = win;
            gnt_d        = '0;
            gnt_d[win]   = 1'b1;
            shadow_d     = bus.PATTERN[int'(win)*PAT_W +: PAT_W];
            bit_d        = '0;
            busy_d       = 1'b1;
            tick_clr     = 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            idx_q    <= '0;
            bit_q    <= '0;
            shadow_q <= '0;
            gnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            idx_q    <= idx_d;
            bit_q    <= bit_d;
            shadow_q <= shadow_d;
            gnt_q    <= gnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign bus.LED  = (state_q == PLAY) ? shadow_q[bit_q] : 1'b0;
    assign bus.GNT  = gnt_q;
    assign bus.BUSY = busy_q;
    assign bus.DONE = done_q;

endmodule

// File: tb/tb_led_pattern_arbiter.sv
// Directed bench for led_pattern_arbiter with N_REQ=4, PAT_W=8, TICK_DIV=4.
module tb_led_pattern_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    logic [7:0] pat [4];

    always #5 clk = ~clk;

    led_pattern_arbiter_if #(.N_REQ(4), .PAT_W(8)) bus ();

    led_pattern_arbiter #(.N_REQ(4), .PAT_W(8), .TICK_DIV(4)) dut (
        .CLK(clk),
        .RST(rst),
        .bus(bus)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".led"},  {31'b0, bus.LED},  32'd0);
        chk({tag, ".gnt"},  {28'b0, bus.GNT},  32'd0);
        chk({tag, ".busy"}, {31'b0, bus.BUSY}, 32'd0);
        chk({tag, ".done"}, {31'b0, bus.DONE}, 32'd0);
    endtask

    // Advances through play cycles 1..n_k of a pattern; the first step is the grant edge.
    task automatic run_pattern(input logic [3:0] g, input logic [7:0] p, input string tag,
                               input int n_k, input int drop_k, input int flip_k);
        for (int k = 1; k <= n_k; k++) begin
            step();
            if (k == drop_k) bus.REQ = 4'b0000;
            if (k == flip_k) bus.PATTERN = ~bus.PATTERN;
            chk($sformatf("%s.gnt[%0d]", tag, k),  {28'b0, bus.GNT},  {28'b0, g});
            chk($sformatf("%s.busy[%0d]", tag, k), {31'b0, bus.BUSY}, 32'd1);
            chk($sformatf("%s.led[%0d]", tag, k),  {31'b0, bus.LED},  {31'b0, p[(k-1)/4]});
            chk($sformatf("%s.done[%0d]", tag, k), {31'b0, bus.DONE}, {31'b0, (k == 32)});
        end
        $display("pattern %s gnt=%b cycles=%0d", tag, g, n_k);
    endtask

    initial begin
        logic [0:7] seq1;
        seq1 = 8'b1100_0101;
        pat[0] = 8'h96;
        pat[1] = 8'hA3;
        pat[2] = 8'hC3;
        pat[3] = 8'h0F;
        bus.REQ = 4'b0000;
        bus.PATTERN = {pat[3], pat[2], pat[1], pat[0]};
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk_idle("reset");
        step();
        chk_idle("idle_noreq");

        // Single request, pattern 0xA3 played LSB-first.
        bus.REQ = 4'b0010;
        for (int k = 1; k <= 32; k++) begin
            step();
            if (k == 1) bus.REQ = 4'b0000;
            chk($sformatf("single.gnt[%0d]", k),  {28'b0, bus.GNT},  32'h2);
            chk($sformatf("single.busy[%0d]", k), {31'b0, bus.BUSY}, 32'd1);
            chk($sformatf("single.led[%0d]", k),  {31'b0, bus.LED},  {31'b0, seq1[(k-1)/4]});
            chk($sformatf("single.done[%0d]", k), {31'b0, bus.DONE}, {31'b0, (k == 32)});
        end
        $display("pattern single gnt=0010 cycles=32");
        step();
        chk_idle("single_end");

        // All requesters from reset: full rotation with no idle gap.
        rst = 1'b1;
        bus.REQ = 4'b1111;
        step();
        rst = 1'b0;
        chk_idle("all_rst");
        run_pattern(4'b0001, pat[0], "all0", 32, 0, 0);
        run_pattern(4'b0010, pat[1], "all1", 32, 0, 0);
        run_pattern(4'b0100, pat[2], "all2", 32, 0, 0);
        run_pattern(4'b1000, pat[3], "all3", 32, 1, 0);
        step();
        chk_idle("all_end");

        // Two requesters held: they alternate.
        bus.REQ = 4'b0101;
        run_pattern(4'b0001, pat[0], "two0", 32, 0, 0);
        run_pattern(4'b0100, pat[2], "two1", 32, 0, 0);
        run_pattern(4'b0001, pat[0], "two2", 32, 0, 0);
        run_pattern(4'b0100, pat[2], "two3", 32, 1, 0);
        step();
        chk_idle("two_end");

        // REQ dropped and PATTERN changed mid-play are ignored.
        bus.REQ = 4'b0001;
        run_pattern(4'b0001, pat[0], "ignore", 32, 5, 10);
        step();
        chk_idle("ignore_end");
        bus.PATTERN = {pat[3], pat[2], pat[1], pat[0]};

        // Asynchronous reset at play cycle 13.
        bus.REQ = 4'b0100;
        run_pattern(4'b0100, pat[2], "pre_rst", 13, 1, 0);
        #1 rst = 1'b1;
        #1 chk_idle("async_rst");
        bus.REQ = 4'b1000;
        step();
        step();
        rst = 1'b0;
        run_pattern(4'b1000, pat[3], "rst_rel", 32, 1, 0);
        step();
        chk_idle("rst_rel_end");

        // Pointer is cleared by reset: a stale pointer of 2 would pick requester 3.
        bus.REQ = 4'b0010;
        run_pattern(4'b0010, pat[1], "ptr_a", 32, 1, 0);
        step();
        chk_idle("ptr_a_end");
        bus.REQ = 4'b0010;
        run_pattern(4'b0010, pat[1], "ptr_b", 3, 1, 0);
        #1 rst = 1'b1;
        bus.REQ = 4'b1001;
        step();
        rst = 1'b0;
        step();
        chk("ptr_rst.gnt", {28'b0, bus.GNT}, 32'h1);
        chk("ptr_rst.led", {31'b0, bus.LED}, {31'b0, pat[0][0]});
        bus.REQ = 4'b0000;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/led_pattern_arbiter.md
# led_pattern_arbiter

Shares the board's single user LED among several status requesters, such as boot, error and heartbeat sources. Each requester offers a fixed-length blink pattern. The block grants the LED to one requester at a time in round-robin order and plays that requester's pattern LSB-first, holding each bit for a programmable number of clock cycles. It sits directly between the requesting logic and the `LED` pin in `top`, where it replaces the free-running pattern counter.

## Interface

Parameters:
- `N_REQ`, default 4: number of requesters. Must be ≥ 2.
- `PAT_W`, default 32: pattern length in bits.
- `TICK_DIV`, default 1048576 (2^20): clock cycles each pattern bit is held. At 16 MHz this is about 65.5 ms per bit. Must be ≥ 2.

Ports:
- `CLK`  in  1: 16 MHz system clock.
- `RST`  in  1: asynchronous, active-high reset.
- `REQ`  in  `N_REQ`: level request, one bit per requester.
- `PATTERN`  in  `N_REQ*PAT_W`: flat pattern bus; requester i occupies `[i*PAT_W +: PAT_W]`.
- `LED`  out  1: drives the user LED.
- `GNT`  out  `N_REQ`: one-hot current owner; all zero when idle.
- `BUSY`  out  1: a pattern is playing.
- `DONE`  out  1: one-cycle pulse on the last cycle of a pattern.

## Operation

- States: `IDLE` and `PLAY`.
- Reset values: `LED`=0, `GNT`=0, `BUSY`=0, `DONE`=0, state=`IDLE`, round-robin pointer=0, tick counter=0, bit index=0.
- **IDLE**
  - `LED`=0.
  - When any `REQ` bit is set at a rising edge, pick the winner by round-robin, searching upward from the pointer with wrap-around.
  - On that same edge: latch the winner's `PATTERN` slice into the shadow register, set `GNT`, clear the tick counter and bit index, go to `PLAY`.
- **PLAY**
  - `LED` = shadow[bit index].
  - The tick counter counts 0..`TICK_DIV-1`. At `TICK_DIV-1` it wraps to 0 and the bit index increments.
- **End of pattern** (bit index = `PAT_W-1` and tick = `TICK_DIV-1`):
  - Assert `DONE` for that cycle.
  - Set the pointer to the granted index + 1, wrapping at `N_REQ`.
  - If any `REQ` is set, re-arbitrate on the same edge and load the next pattern with no idle gap; this may grant the same requester again if it is the only one.
  - Otherwise go to `IDLE`.
- **Non-preemptive:** once granted, the pattern always completes.
  - Deasserting `REQ` during `PLAY` is ignored.
  - Changes on `PATTERN` after the latch are ignored.
- **Round-robin:** the search starts at the pointer. The just-served requester therefore has lowest priority at the next arbitration.
- **Reset mid-operation:** `RST` forces all reset values immediately, asynchronously. Playback is abandoned and nothing is replayed after release.

## Timing

- `REQ` high before edge t causes `GNT`, `BUSY` and `LED` = bit 0 to be valid after edge t. This is 1 cycle of latency.
- One pattern occupies exactly `PAT_W*TICK_DIV` cycles with `BUSY`=1.
- `DONE` is high in the final cycle of that window.
- `GNT` changes only at pattern boundaries and is one-hot or zero in every cycle.
- Widths:
  - Tick counter: `$clog2(TICK_DIV)` bits.
  - Bit index: `$clog2(PAT_W)` bits, compared against `PAT_W-1`, so `PAT_W` need not be a power of two.
  - Pointer: `$clog2(N_REQ)` bits.
- All outputs are registered except `LED`, which is a mux of registered state. There are no combinational paths from `REQ` or `PATTERN` to any output.

## Structure

- Package `led_arb_pkg` holds:
  - the state enum (`IDLE`, `PLAY`);
  - width helper constants derived from the parameters.
- Sub-module `led_tick_gen`: a prescaler with `TICK_DIV`. It outputs a one-cycle `tick` pulse and has a synchronous clear that the arbiter uses on grant.
- Round-robin selection is a combinational function in the top of this block.

## Test plan

Bench configuration: `N_REQ`=4, `PAT_W`=8, `TICK_DIV`=4.

- **Single request.** `REQ`=0010, pattern1=8'b1010_0011.
  - `GNT`=0010 one cycle later.
  - `LED` plays 1,1,0,0,0,1,0,1, each bit for 4 cycles.
  - `DONE` pulses at cycle 32 of play.
  - `BUSY` falls next cycle with `REQ` low.
- **All request.** `REQ`=1111 from reset.
  - Grants run 0001, 0010, 0100, 1000, each 32 cycles.
  - No idle cycle between patterns.
- **Two requesters held.** `REQ`=0101 held high.
  - Grants alternate 0001, 0100, 0001, and so on; requester 2 is never starved.
- **Ignored inputs during play.**
  - `REQ` dropped at cycle 5 of play: pattern still completes, `DONE` still pulses.
  - `PATTERN` changed mid-play: `LED` still follows the latched value.
- **Reset mid-play.** `RST` asserted at cycle 13 of play.
  - `LED`, `GNT`, `BUSY` and `DONE` go to 0 without waiting for a `CLK` edge.
  - After release with `REQ`=1000, the grant goes to 1000 (pointer back at 0) and playback starts at bit 0.
